// File: rtl/comp_pkg.sv
// Shared types and helpers for the min/max comparator controller.
// Holds the FSM state encoding, ordering-mode constants and the key transform.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic CMP_UNSIGNED = 1'b0;
    localparam logic CMP_SIGNED   = 1'b1;

    localparam int unsigned KEY_MAX_W = 64;
    localparam int unsigned KEY_IDX_W = $clog2(KEY_MAX_W);

    // Signed ordering becomes unsigned ordering once the sign bit is flipped (offset binary).
    function automatic logic [KEY_MAX_W-1:0] key_xform(
        input logic [KEY_MAX_W-1:0] data,
        input int unsigned          width,
        input logic                 mode
    );
        logic [KEY_MAX_W-1:0] key;
        logic [KEY_IDX_W-1:0] msb;
        key = data;
        msb = KEY_IDX_W'(width - 1);
        if (mode == CMP_SIGNED) begin
            key[msb] = ~data[msb];
        end
        return key;
    endfunction

endpackage

// File: rtl/comp_bin_core.sv
// Combinational unsigned magnitude compare of two N-bit keys.
module comp_bin_core #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = ~gt & ~eq;

endmodule

// File: rtl/comp_minmax_ctrl.sv
// Burst controller tracking max/min values and their indices over a valid/ready stream.
// One shared compare path per extremum; stored results keep the original encoding.
module comp_minmax_ctrl
    import comp_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Start,
    input  logic [CNT_W-1:0] i_Len,
    input  logic             i_Signed,
    input  logic             i_Valid,
    input  logic [N-1:0]     i_Data,
    output logic             o_Ready,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Err,
    output logic [N-1:0]     o_Max,
    output logic [N-1:0]     o_Min,
    output logic [CNT_W-1:0] o_MaxIdx,
    output logic [CNT_W-1:0] o_MinIdx
);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] len;
    logic             mode;
    logic [CNT_W-1:0] idx;
    logic             start_ok;
    logic             start_bad;

    logic             xfer;
    logic             last;
    logic             len_ok;
    logic [N-1:0]     key_new;
    logic [N-1:0]     key_max;
    logic [N-1:0]     key_min;
    logic             max_gt, max_eq, max_lt;
    logic             min_gt, min_eq, min_lt;
    logic             unused_flags;

    assign xfer   = i_Valid & o_Ready;
    assign last   = (idx == CNT_W'(len - CNT_W'(1)));
    assign len_ok = (i_Len != '0) && (i_Len <= CNT_W'(DEPTH));

    assign key_new = N'(key_xform(KEY_MAX_W'(i_Data), N, mode));
    assign key_max = N'(key_xform(KEY_MAX_W'(o_Max), N, mode));
    assign key_min = N'(key_xform(KEY_MAX_W'(o_Min), N, mode));

    comp_bin_core #(.N(N)) u_cmp_max (
        .a  (key_new),
        .b  (key_max),
        .gt (max_gt),
        .eq (max_eq),
        .lt (max_lt)
    );

    comp_bin_core #(.N(N)) u_cmp_min (
        .a  (key_new),
        .b  (key_min),
        .gt (min_gt),
        .eq (min_eq),
        .lt (min_lt)
    );

    // Ties leave the stored extremum alone, so only strict gt/lt matter here.
    assign unused_flags = ^{max_eq, max_lt, min_gt, min_eq};

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state)
            IDLE: begin
                if (i_Start) begin
                    if (len_ok) begin
                        start_ok = 1'b1;
                        state_nx = RUN;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer && last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status flags are registered decodes of the next state.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Ready <= 1'b0;
            o_Busy  <= 1'b0;
            o_Done  <= 1'b0;
            o_Err   <= 1'b0;
            len     <= '0;
            mode    <= CMP_UNSIGNED;
            idx     <= '0;
        end else begin
            o_Ready <= (state_nx == RUN);
            o_Busy  <= (state_nx == RUN);
            o_Done  <= (state_nx == DONE);
            o_Err   <= start_bad;
            if (start_ok) begin
                len  <= i_Len;
                mode <= i_Signed;
                idx  <= '0;
            end else if (xfer) begin
                idx <= CNT_W'(idx + CNT_W'(1));
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Max    <= '0;
            o_Min    <= '0;
            o_MaxIdx <= '0;
            o_MinIdx <= '0;
        end else if (xfer) begin
            if (idx == '0) begin
                o_Max    <= i_Data;
                o_Min    <= i_Data;
                o_MaxIdx <= '0;
                o_MinIdx <= '0;
            end else begin
                if (max_gt) begin
                    o_Max    <= i_Data;
                    o_MaxIdx <= idx;
                end
                if (min_lt) begin
                    o_Min    <= i_Data;
                    o_MinIdx <= idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_minmax_ctrl.sv
// Directed bench for comp_minmax_ctrl: bursts, signed ordering, ties, stalls, errors, reset.
module tb_comp_minmax_ctrl;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             sgn;
    logic             valid;
    logic [N-1:0]     data;
    logic             ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [N-1:0]     max_v;
    logic [N-1:0]     min_v;
    logic [CNT_W-1:0] max_idx;
    logic [CNT_W-1:0] min_idx;

    int checks = 0;
    int errors = 0;

    comp_minmax_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
        .i_Clk    (clk),
        .i_Rst_n  (rst_n),
        .i_Start  (start),
        .i_Len    (len),
        .i_Signed (sgn),
        .i_Valid  (valid),
        .i_Data   (data),
        .o_Ready  (ready),
        .o_Busy   (busy),
        .o_Done   (done),
        .o_Err    (err),
        .o_Max    (max_v),
        .o_Min    (min_v),
        .o_MaxIdx (max_idx),
        .o_MinIdx (min_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] mx, input int mxi,
                                input logic [7:0] mn, input int mni);
        check({tag, "_max"},     32'(max_v),   32'(mx));
        check({tag, "_max_idx"}, 32'(max_idx), 32'(mxi));
        check({tag, "_min"},     32'(min_v),   32'(mn));
        check({tag, "_min_idx"}, 32'(min_idx), 32'(mni));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same offset.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l, input logic s);
        start = 1'b1;
        len   = CNT_W'(l);
        sgn   = s;
        step();
        start = 1'b0;
    endtask

    task automatic do_beat(input logic [7:0] d);
        valid = 1'b1;
        data  = d;
        step();
        valid = 1'b0;
        data  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        len   = '0;
        sgn   = 1'b0;
        valid = 1'b0;
        data  = '0;
        #12;
        check("rst_ready", 32'(ready), 32'(0));
        check("rst_busy",  32'(busy),  32'(0));
        check("rst_done",  32'(done),  32'(0));
        check("rst_err",   32'(err),   32'(0));
        check_result("rst", 8'h00, 0, 8'h00, 0);
        rst_n = 1'b1;
        step();

        // Unsigned burst of four.
        do_start(4, 1'b0);
        check("u_busy",  32'(busy),  32'(1));
        check("u_ready", 32'(ready), 32'(1));
        do_beat(8'h10);
        do_beat(8'hF0);
        do_beat(8'h03);
        check("u_done_early", 32'(done), 32'(0));
        do_beat(8'h80);
        check("u_done",  32'(done),  32'(1));
        check("u_ready_drop", 32'(ready), 32'(0));
        check_result("u", 8'hF0, 1, 8'h03, 2);
        step();
        check("u_done_pulse", 32'(done), 32'(0));
        check("u_busy_idle",  32'(busy), 32'(0));
        check_result("u_hold", 8'hF0, 1, 8'h03, 2);

        // Same data, two's-complement ordering.
        do_start(4, 1'b1);
        do_beat(8'h10);
        do_beat(8'hF0);
        do_beat(8'h03);
        do_beat(8'h80);
        check("s_done", 32'(done), 32'(1));
        check_result("s", 8'h10, 0, 8'h80, 3);
        step();

        // Ties keep the first index.
        do_start(3, 1'b0);
        do_beat(8'h55);
        do_beat(8'h55);
        do_beat(8'h55);
        check("tie_done", 32'(done), 32'(1));
        check_result("tie", 8'h55, 0, 8'h55, 0);
        step();

        // Single-sample burst.
        do_start(1, 1'b0);
        check("one_done_early", 32'(done), 32'(0));
        do_beat(8'h7A);
        check("one_done", 32'(done), 32'(1));
        check_result("one", 8'h7A, 0, 8'h7A, 0);
        step();

        // Stalls with valid pattern 1-0-0-1-1 and a stray start mid-burst.
        do_start(3, 1'b0);
        do_beat(8'h20);
        data  = 8'hFF;
        start = 1'b1;
        len   = CNT_W'(1);
        step();
        start = 1'b0;
        step();
        check("stall_busy", 32'(busy), 32'(1));
        check("stall_done", 32'(done), 32'(0));
        check_result("stall_mid", 8'h20, 0, 8'h20, 0);
        do_beat(8'h05);
        check("stall_done2", 32'(done), 32'(0));
        do_beat(8'h40);
        check("stall_done3", 32'(done), 32'(1));
        check_result("stall", 8'h40, 2, 8'h05, 1);
        step();

        // Illegal lengths, then a legal start.
        do_start(0, 1'b0);
        check("err0",      32'(err),  32'(1));
        check("err0_busy", 32'(busy), 32'(0));
        step();
        check("err0_pulse", 32'(err), 32'(0));
        do_start(DEPTH + 1, 1'b0);
        check("err17",      32'(err),  32'(1));
        check("err17_busy", 32'(busy), 32'(0));
        step();
        do_start(2, 1'b0);
        check("legal_busy", 32'(busy), 32'(1));
        check("legal_err",  32'(err),  32'(0));
        do_beat(8'h01);
        do_beat(8'h02);
        check("legal_done", 32'(done), 32'(1));
        check_result("legal", 8'h02, 1, 8'h01, 0);
        step();

        // Reset in the middle of a burst.
        do_start(4, 1'b0);
        do_beat(8'hFE);
        do_beat(8'h00);
        rst_n = 1'b0;
        #1;
        check("mr_busy",  32'(busy),  32'(0));
        check("mr_ready", 32'(ready), 32'(0));
        check("mr_done",  32'(done),  32'(0));
        check_result("mr", 8'h00, 0, 8'h00, 0);
        #3;
        rst_n = 1'b1;
        step();
        check("mr_idle", 32'(busy), 32'(0));
        do_start(2, 1'b0);
        do_beat(8'h30);
        do_beat(8'h31);
        check("mr_done2", 32'(done), 32'(1));
        check_result("mr_new", 8'h31, 1, 8'h30, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
